// File: rtl/dram_pkg.sv
// Shared definitions for the dual-port DRAM model with refresh.
// Contents:
//   state_e           - refresh controller state (IDLE / REFRESH)
//   DEF_*             - default values for the top-level parameters
package dram_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_REFRESH = 1'b1
  } state_e;

  localparam int DEF_DATA_W         = 16;
  localparam int DEF_ADDR_W         = 4;
  localparam int DEF_REFRESH_PERIOD = 64;
  localparam int DEF_RETENTION      = 200;
  localparam int DEF_DECAY_EN       = 1;

endpackage

// File: rtl/dram_refresh_ctrl.sv
// Refresh controller: idle timer, IDLE/REFRESH state machine and sweep row
// counter.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   refresh_en_i    - manual refresh request (ignored while sweeping)
//   state_o         - current state
//   row_o           - row being refreshed this cycle (valid in REFRESH)
//   refresh_done_o  - one-cycle pulse after the last row has been swept
module dram_refresh_ctrl
  import dram_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_en_i,
  output state_e            state_o,
  output logic [ADDR_W-1:0] row_o,
  output logic              refresh_done_o
);

  localparam int TIMER_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_PERIOD - 1);
  localparam logic [ADDR_W-1:0]  ROW_LAST   = '1;

  state_e              state_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [ADDR_W-1:0]   row_q;
  logic                done_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (refresh_en_i || timer_q == TIMER_LAST) begin
            state_q <= ST_REFRESH;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_REFRESH: begin
          // Timer stays at zero for the whole sweep; refresh_en is ignored.
          if (row_q == ROW_LAST) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state_o        = state_q;
  assign row_o          = row_q;
  assign refresh_done_o = done_q;

endmodule

// File: rtl/dram_dp_refresh.sv
// Dual-port DRAM behavioural block with periodic/manual refresh and a
// retention-loss (decay) model.
// Ports (p in {a,b}):
//   clk, rst                 - clock, synchronous active-high reset
//   enable_p/we_p/addr_p     - request, 1=write 0=read, address
//   data_in_p                - write data
//   data_out_p / valid_p     - read data, one-cycle strobe (latency 1)
//   ready_p                  - request accepted this cycle (state IDLE)
//   refresh_en               - manual refresh request
//   refresh_busy             - sweep in progress
//   refresh_done             - sweep-complete pulse
//   collision                - both ports wrote the same address (A wins)
module dram_dp_refresh
  import dram_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int RETENTION      = DEF_RETENTION,
  parameter int DECAY_EN       = DEF_DECAY_EN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_in_a,
  output logic [DATA_W-1:0] data_out_a,
  output logic              valid_a,
  output logic              ready_a,
  input  logic              enable_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_in_b,
  output logic [DATA_W-1:0] data_out_b,
  output logic              valid_b,
  output logic              ready_b,
  input  logic              refresh_en,
  output logic              refresh_busy,
  output logic              refresh_done,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AGE_W = $clog2(RETENTION + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(RETENTION);

  state_e            state;
  logic [ADDR_W-1:0] row;

  dram_refresh_ctrl #(
    .ADDR_W        (ADDR_W),
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .refresh_en_i  (refresh_en),
    .state_o       (state),
    .row_o         (row),
    .refresh_done_o(refresh_done)
  );

  assign ready_a      = (state == ST_IDLE);
  assign ready_b      = (state == ST_IDLE);
  assign refresh_busy = (state == ST_REFRESH);

  logic acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
  assign acc_a = enable_a & ready_a;
  assign acc_b = enable_b & ready_b;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;
  assign rd_a  = acc_a & ~we_a;
  assign rd_b  = acc_b & ~we_b;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AGE_W-1:0]  age_q [DEPTH];
  logic [AGE_W-1:0]  age_d [DEPTH];

  // Per-word next state: age, decay, then writes (B first so A wins a tie).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: every always_comb output gets a default before any condition,
      // otherwise an unassigned path would infer a latch.
      mem_d[i] = mem_q[i];
      age_d[i] = age_q[i];
      if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
      if ((acc_a && addr_a == ADDR_W'(i)) ||
          (acc_b && addr_b == ADDR_W'(i)) ||
          (refresh_busy && row == ADDR_W'(i)))
        age_d[i] = '0;
      // A word touched this cycle has age_d==0, so it can never decay here.
      if (DECAY_EN != 0 && age_d[i] == AGE_MAX) mem_d[i] = '0;
      if (wr_b && addr_b == ADDR_W'(i)) mem_d[i] = data_in_b;
      if (wr_a && addr_a == ADDR_W'(i)) mem_d[i] = data_in_a;
    end
  end

  // NOTE: the storage array is reset explicitly because the model requires
  // all words to read as zero after rst; real RAM macros could not do this.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  logic [DATA_W-1:0] data_out_a_q, data_out_b_q;
  logic              valid_a_q, valid_b_q, collision_q;

  // Reads sample mem_q before this edge's writes: read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_a_q <= '0;
      data_out_b_q <= '0;
      valid_a_q    <= 1'b0;
      valid_b_q    <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      valid_a_q   <= rd_a;
      valid_b_q   <= rd_b;
      collision_q <= wr_a & wr_b & (addr_a == addr_b);
      if (rd_a) data_out_a_q <= mem_q[addr_a];
      if (rd_b) data_out_b_q <= mem_q[addr_b];
    end
  end

  assign data_out_a = data_out_a_q;
  assign data_out_b = data_out_b_q;
  assign valid_a    = valid_a_q;
  assign valid_b    = valid_b_q;
  assign collision  = collision_q;

endmodule

// File: tb/tb_dram_dp_refresh.sv
// Self-checking bench for dram_dp_refresh: directed scenarios plus randomized
// traffic compared against a cycle-stamp reference model.
module tb_dram_dp_refresh;

  localparam int DEPTH  = 16;
  localparam int PERIOD = 64;
  localparam int RET    = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main DUT (default parameters) ----------------
  logic        rst, en_a, we_a, en_b, we_b, ren;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;
  logic        valid_a, valid_b, ready_a, ready_b, busy, done, coll;

  dram_dp_refresh dut (
    .clk(clk), .rst(rst),
    .enable_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_in_a(din_a),
    .data_out_a(dout_a), .valid_a(valid_a), .ready_a(ready_a),
    .enable_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_in_b(din_b),
    .data_out_b(dout_b), .valid_b(valid_b), .ready_b(ready_b),
    .refresh_en(ren), .refresh_busy(busy), .refresh_done(done),
    .collision(coll)
  );

  // ---------------- decay pair (retention 50, long period) ----------------
  logic        rst2, en2, we2;
  logic [3:0]  addr2;
  logic [15:0] din2;
  logic        zero_bit = 1'b0;
  logic [3:0]  zero_addr = 4'h0;
  logic [15:0] zero_data = 16'h0;
  logic [15:0] dk_out_a, dk_out_b, kp_out_a, kp_out_b;
  logic        dk_val_a, dk_val_b, dk_rdy_a, dk_rdy_b, dk_busy, dk_done, dk_coll;
  logic        kp_val_a, kp_val_b, kp_rdy_a, kp_rdy_b, kp_busy, kp_done, kp_coll;

  dram_dp_refresh #(.REFRESH_PERIOD(1024), .RETENTION(50), .DECAY_EN(1)) u_decay (
    .clk(clk), .rst(rst2),
    .enable_a(en2), .we_a(we2), .addr_a(addr2), .data_in_a(din2),
    .data_out_a(dk_out_a), .valid_a(dk_val_a), .ready_a(dk_rdy_a),
    .enable_b(zero_bit), .we_b(zero_bit), .addr_b(zero_addr), .data_in_b(zero_data),
    .data_out_b(dk_out_b), .valid_b(dk_val_b), .ready_b(dk_rdy_b),
    .refresh_en(zero_bit), .refresh_busy(dk_busy), .refresh_done(dk_done),
    .collision(dk_coll)
  );

  dram_dp_refresh #(.REFRESH_PERIOD(1024), .RETENTION(50), .DECAY_EN(0)) u_keep (
    .clk(clk), .rst(rst2),
    .enable_a(en2), .we_a(we2), .addr_a(addr2), .data_in_a(din2),
    .data_out_a(kp_out_a), .valid_a(kp_val_a), .ready_a(kp_rdy_a),
    .enable_b(zero_bit), .we_b(zero_bit), .addr_b(zero_addr), .data_in_b(zero_data),
    .data_out_b(kp_out_b), .valid_b(kp_val_b), .ready_b(kp_rdy_b),
    .refresh_en(zero_bit), .refresh_busy(kp_busy), .refresh_done(kp_done),
    .collision(kp_coll)
  );

  // ---------------- reference model ----------------
  // Ages are kept as the edge number of the last touch; a word is lost once
  // RET edges have passed since then.
  logic [15:0] m_mem [DEPTH];
  int          m_last [DEPTH];
  bit          m_busy;
  int          m_idle, m_row, cyc;
  logic [15:0] e_out_a, e_out_b;
  bit          e_val_a, e_val_b, e_done, e_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ready_a", 32'(ready_a), 32'(!m_busy));
    check("ready_b", 32'(ready_b), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("valid_a", 32'(valid_a), 32'(e_val_a));
    check("valid_b", 32'(valid_b), 32'(e_val_b));
    check("data_out_a", 32'(dout_a), 32'(e_out_a));
    check("data_out_b", 32'(dout_b), 32'(e_out_b));
    check("refresh_done", 32'(done), 32'(e_done));
    check("collision", 32'(coll), 32'(e_col));
  endtask

  task automatic model(input logic r, input logic ea, input logic wa, input logic [3:0] aa,
                       input logic [15:0] da, input logic eb, input logic wb,
                       input logic [3:0] ab, input logic [15:0] db, input logic rn);
    int n;
    bit acc_a, acc_b;
    n = cyc + 1;
    if (r) begin
      for (int w = 0; w < DEPTH; w++) begin m_mem[w] = '0; m_last[w] = n; end
      m_busy = 0; m_idle = 0; m_row = 0;
      e_out_a = '0; e_out_b = '0; e_val_a = 0; e_val_b = 0; e_done = 0; e_col = 0;
    end else begin
      acc_a = ea && !m_busy;
      acc_b = eb && !m_busy;
      e_val_a = acc_a && !wa;
      e_val_b = acc_b && !wb;
      if (e_val_a) e_out_a = m_mem[aa];
      if (e_val_b) e_out_b = m_mem[ab];
      e_col  = acc_a && wa && acc_b && wb && (aa == ab);
      e_done = 0;
      if (acc_b && wb) m_mem[ab] = db;
      if (acc_a && wa) m_mem[aa] = da;
      if (acc_a) m_last[aa] = n;
      if (acc_b) m_last[ab] = n;
      if (m_busy) begin
        m_last[m_row] = n;
        m_row++;
        if (m_row == DEPTH) begin m_busy = 0; m_row = 0; e_done = 1; end
      end else if (rn || m_idle == PERIOD - 1) begin
        m_busy = 1; m_idle = 0;
      end else begin
        m_idle++;
      end
      for (int w = 0; w < DEPTH; w++)
        if (n - m_last[w] >= RET) m_mem[w] = '0;
    end
  endtask

  task automatic step(input logic r, input logic ea, input logic wa, input logic [3:0] aa,
                      input logic [15:0] da, input logic eb, input logic wb,
                      input logic [3:0] ab, input logic [15:0] db, input logic rn);
    rst = r; en_a = ea; we_a = wa; addr_a = aa; din_a = da;
    en_b = eb; we_b = wb; addr_b = ab; din_b = db; ren = rn;
    model(r, ea, wa, aa, da, eb, wb, ab, db, rn);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
  endtask

  task automatic step2(input logic r, input logic e, input logic w, input logic [3:0] a,
                       input logic [15:0] d);
    rst2 = r; en2 = e; we2 = w; addr2 = a; din2 = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    logic ea, wa, eb, wb, rn, narrow;
    logic [3:0] aa, ab;
    logic [15:0] da, db;

    cyc = 0;
    rst = 1'b1; en_a = 0; we_a = 0; addr_a = 0; din_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; din_b = 0; ren = 0;
    rst2 = 1'b1; en2 = 0; we2 = 0; addr2 = 0; din2 = 0;
    @(negedge clk);

    // ---- retention loss with and without decay ----
    step2(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    check("decay_reset_ready", 32'(dk_rdy_a), 32'd1);
    check("decay_reset_dout", 32'(dk_out_a), 32'h0);
    step2(1'b0, 1'b1, 1'b1, 4'h1, 16'h1111);
    step2(1'b0, 1'b1, 1'b1, 4'h2, 16'h2222);
    for (int i = 0; i < 10; i++) step2(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    step2(1'b0, 1'b1, 1'b0, 4'h2, 16'h0);
    check("young_decay_valid", 32'(dk_val_a), 32'd1);
    check("young_decay_data", 32'(dk_out_a), 32'h2222);
    check("young_keep_data", 32'(kp_out_a), 32'h2222);
    for (int i = 0; i < 50; i++) step2(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    step2(1'b0, 1'b1, 1'b0, 4'h1, 16'h0);
    check("old_decay_valid", 32'(dk_val_a), 32'd1);
    check("old_decay_data", 32'(dk_out_a), 32'h0);
    check("old_keep_valid", 32'(kp_val_a), 32'd1);
    check("old_keep_data", 32'(kp_out_a), 32'h1111);
    step2(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    check("decay_valid_drop", 32'(dk_val_a), 32'd0);
    check("decay_port_b_idle", 32'(dk_val_b | kp_val_b | dk_coll | kp_coll), 32'd0);

    // ---- main DUT: reset state and automatic refresh timing ----
    step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    for (int i = 0; i < PERIOD - 1; i++) idle();
    check("auto_not_yet", 32'(busy), 32'd0);
    idle();
    check("auto_busy_rises", 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
      check("sweep_drops_read", 32'(valid_a), 32'd0);
    end
    check("auto_done", 32'(done), 32'd1);
    check("auto_back_idle", 32'(ready_a), 32'd1);

    // ---- basic dual-port write then read ----
    step(1'b0, 1'b1, 1'b1, 4'h4, 16'hA5A5, 1'b1, 1'b1, 4'h8, 16'h5A5A, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h4, 16'h0, 1'b1, 1'b0, 4'h8, 16'h0, 1'b0);
    check("rd_valid_a", 32'(valid_a), 32'd1);
    check("rd_valid_b", 32'(valid_b), 32'd1);
    check("rd_data_a", 32'(dout_a), 32'hA5A5);
    check("rd_data_b", 32'(dout_b), 32'h5A5A);

    // ---- same-address write collision ----
    step(1'b0, 1'b1, 1'b1, 4'h3, 16'hDEAD, 1'b1, 1'b1, 4'h3, 16'hBEEF, 1'b0);
    check("collision_pulse", 32'(coll), 32'd1);
    idle();
    check("collision_clear", 32'(coll), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h3, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    check("collision_winner", 32'(dout_a), 32'hDEAD);

    // ---- read-first on one address ----
    step(1'b0, 1'b1, 1'b0, 4'h4, 16'h0, 1'b1, 1'b1, 4'h4, 16'h1234, 1'b0);
    check("read_first", 32'(dout_a), 32'hA5A5);

    // ---- manual refresh ----
    busy_cnt = 0; done_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1);
    if (busy) busy_cnt++;
    for (int i = 0; i < 19; i++) begin
      idle();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("manual_busy_cycles", 32'(busy_cnt), 32'd16);
    check("manual_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < DEPTH / 2; i++)
      step(1'b0, 1'b1, 1'b0, 4'(i), 16'h0, 1'b1, 1'b0, 4'(i + DEPTH / 2), 16'h0, 1'b0);

    // ---- randomized traffic ----
    for (int k = 0; k < 400; k++) begin
      narrow = 1'($urandom_range(0, 1));
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      wa = 1'($urandom_range(0, 1));
      wb = 1'($urandom_range(0, 1));
      aa = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      ab = narrow ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      da = 16'($urandom);
      db = 16'($urandom);
      rn = ($urandom_range(0, 39) == 0);
      step(1'b0, ea, wa, aa, da, eb, wb, ab, db, rn);
    end

    // ---- reset in the middle of a sweep ----
    step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) idle();
    step(1'b1, 1'b1, 1'b1, 4'h5, 16'hFFFF, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0);
    check("midsweep_ready", 32'(ready_a), 32'd1);
    check("midsweep_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'h5, 16'h0, 1'b1, 1'b0, 4'hC, 16'h0, 1'b0);
    check("post_reset_data_a", 32'(dout_a), 32'h0);
    check("post_reset_data_b", 32'(dout_b), 32'h0);
    check("post_reset_valid", 32'(valid_a), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_dp_refresh.md
DRAM_DP_REFRESH -- requirements
Module: dram_dp_refresh

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter REFRESH_PERIOD, default 64, idle cycles between automatic refreshes.
REQ-004 SHALL provide parameter RETENTION, default 200, cycles a word survives without access or refresh.
REQ-005 SHALL provide parameter DECAY_EN, default 1, enabling the retention-loss model.
REQ-006 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-008 SHALL have, per port p in {a,b}: enable_p  in  1  request; we_p  in  1  1=write, 0=read; addr_p  in  ADDR_W  address.
REQ-009 SHALL have, per port p: data_in_p  in  DATA_W  write data; data_out_p  out  DATA_W  read data; valid_p  out  1  read-data strobe; ready_p  out  1  request accepted.
REQ-010 SHALL have: refresh_en  in  1  manual refresh request; refresh_busy  out  1  sweep active; refresh_done  out  1  sweep-complete pulse; collision  out  1  same-address write pulse.

Function
REQ-011 SHALL implement FSM states IDLE and REFRESH; ready_a = ready_b = (state==IDLE), combinational; refresh_busy = (state==REFRESH).
REQ-012 SHALL accept a port request when enable_p & ready_p; requests while not ready are dropped, never queued.
REQ-013 SHALL perform an accepted write at the same clock edge; an accepted read SHALL drive data_out_p and pulse valid_p one cycle later (latency 1).
REQ-014 SHALL hold data_out_p between reads; valid_p high only one cycle per accepted read.
REQ-015 SHALL use read-first semantics: a read and a write to the same address in one cycle returns the old word.
REQ-016 SHALL, on both ports writing the same address in one cycle, store port A data and pulse collision for one cycle; different addresses write both.
REQ-017 SHALL count idle cycles in a refresh timer; timer reaching REFRESH_PERIOD-1, or refresh_en high, in IDLE SHALL enter REFRESH next cycle, timer cleared.
REQ-018 SHALL ignore refresh_en while in REFRESH; a port request accepted in the triggering IDLE cycle completes normally.
REQ-019 SHALL in REFRESH sweep row counter 0..DEPTH-1, one word per cycle, contents unchanged, clearing that word's age; total DEPTH cycles.
REQ-020 SHALL on the final sweep cycle pulse refresh_done for one cycle and return to IDLE with row counter 0.
REQ-021 SHALL keep a per-word age counter, saturating at RETENTION, incremented every cycle; cleared by accepted read, write, or refresh of that word.
REQ-022 SHALL, when DECAY_EN=1 and a word's age reaches RETENTION, clear that word to 0 at that edge; DECAY_EN=0 disables clearing.

Reset
REQ-023 SHALL on rst: state IDLE, timer 0, row counter 0, all ages 0, all memory words 0.
REQ-024 SHALL on rst: data_out_a/b 0, valid_a/b 0, refresh_done 0, collision 0; rst overrides any request or sweep in progress.

Structure
REQ-025 SHALL place the FSM state enum and default parameter constants in shared package dram_pkg.
REQ-026 SHALL implement timer, FSM and row counter as sub-module dram_refresh_ctrl; storage, ports and ages in the top.
REQ-027 SHALL size the age counter as $clog2(RETENTION+1) bits and the timer as $clog2(REFRESH_PERIOD) bits.

Verification
REQ-028 Write A5A5@4 via A and 5A5A@8 via B, then read both -> next cycle valid_a=valid_b=1, data_out_a=A5A5, data_out_b=5A5A.
REQ-029 Both ports write addr 3, A=DEAD, B=BEEF -> collision pulses once; subsequent read of 3 returns DEAD.
REQ-030 Pulse refresh_en in IDLE -> ready low and refresh_busy high for 16 cycles, refresh_done single pulse, all stored data intact.
REQ-031 Idle after reset, no requests -> refresh_busy rises after 64 cycles; enable_a held during sweep gets no valid_a.
REQ-032 REFRESH_PERIOD=1024, RETENTION=50: write 1111@1, idle 60 cycles, read 1 -> 0000; same with DECAY_EN=0 -> 1111.
REQ-033 Assert rst mid-sweep -> next cycle IDLE, ready_a=1, refresh_busy=0, read of any address returns 0000.
